random_range_gen: RTL and testbench
===================================

Name: random_range_gen

Overview:
- Parametrised pseudo-random source built on a maximal-length Fibonacci LFSR.
- Adds three things to a plain LFSR: runtime seed loading, zero-lockup protection, and a request/valid handshake.
- Each request returns a value uniformly distributed in [0, range_lim), produced by bounded rejection sampling.
- Used by the map-generation FSM for obstacle size and position, and by the game FSM for pickup placement.

Parameters:
- WIDTH, 10, width of the LFSR state, range_lim and out.
- TAPS, 10'h240, feedback tap mask; bit i set means state[i] feeds the XOR. Bit WIDTH-1 must be set. The default is x^10+x^7+1.
- SEED, 10'h02F, reset seed; also substituted whenever a zero seed is loaded.
- MAX_TRIES, 8, number of rejection attempts before the fallback value is used (legal range 1..255).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- seed_load  in  1  when high, load seed into the LFSR on this edge.
- seed  in  WIDTH  seed value; a value of 0 is replaced by SEED.
- req  in  1  request a ranged draw; sampled only in IDLE.
- range_lim  in  WIDTH  exclusive upper bound, captured when req is accepted; 0 means the full 2^WIDTH range.
- busy  out  1  high while in DRAW.
- valid  out  1  one-cycle pulse; out is valid while valid is high.
- out  out  WIDTH  drawn value; held until the next valid.
- fallback  out  1  qualified by valid; high when the rejection budget was exhausted.
- lfsr_state  out  WIDTH  raw LFSR state, for free-running uses.

Behaviour:
- Reset (async, Reset_n low):
  - LFSR state = SEED.
  - FSM = IDLE.
  - busy = 0, valid = 0, out = 0, fallback = 0.
  - Try counter = 0, captured range = 0.
- LFSR:
  - Advances every cycle, independent of the FSM.
  - Next state = {state[WIDTH-2:0], fb}, where fb = XOR-reduce(state & TAPS).
  - seed_load has priority over stepping: state <= (seed == 0) ? SEED : seed.
  - The state can never become 0.
- Mask:
  - mask = smallest (2^k - 1) such that mask >= range - 1.
  - range 0 means mask is all ones. Range 1 gives mask 0.
  - The mask is computed combinationally from the captured range, at most WIDTH-deep priority logic.
- Candidate:
  - cand = state & mask, taken from the current (pre-step) state.
  - Accepted if range == 0 or cand < range.
- FSM IDLE:
  - If req is high: capture range_lim, clear the try counter, and go to DRAW.
  - busy rises on the next cycle.
  - req while busy is ignored, with no queueing.
- FSM DRAW, each cycle:
  - Accept: out <= cand, fallback <= 0, valid <= 1, go to IDLE.
  - Reject with counter = MAX_TRIES - 1: out <= cand - range, fallback <= 1, valid <= 1, go to IDLE. This value is always < range because cand <= 2*range - 1.
  - Reject otherwise: increment the counter and stay in DRAW.
- Latency:
  - req accepted at edge k; first evaluation at edge k+1.
  - valid is high in the cycle after edge k+1+n, where n is the number of rejections (n <= MAX_TRIES - 1).
  - Best case: valid is asserted 2 cycles after req is sampled.
  - Worst case: MAX_TRIES + 1 cycles.
- valid:
  - Pulses for exactly 1 cycle.
  - A new req may be sampled in the same cycle valid is high, since the FSM is already in IDLE.
- Boundary conditions:
  - range_lim = 1: out = 0 on the first evaluation, fallback = 0.
  - range_lim = 0: always accepted first try; out = raw state.
  - seed_load during DRAW: the draw continues using the newly loaded state from the next cycle.
  - seed_load together with req in IDLE: both take effect.
  - Reset asserted mid-draw: immediate return to reset values; no valid is emitted.
  - range_lim changes during DRAW: ignored, because the range was captured at accept.

Decomposition:
- Package rand_pkg:
  - state enum {IDLE, DRAW}.
  - Default TAPS constants per width (8: 8'hB8, 10: 10'h240, 16: 16'hB400).
  - Function mask_for(range) returning the mask.
- Sub-module lfsr_core (WIDTH, TAPS, SEED):
  - Inputs: Clk, Reset_n, seed_load, seed.
  - Output: state.
  - Contains the stepping, seed substitution and zero guard.
- random_range_gen holds the FSM, counter, compare and output registers.

Test Plan:
1. Reset release, no seed_load → lfsr_state sequence 0x02F, 0x05E, 0x0BD on successive cycles; the period returns to 0x02F after exactly 1023 steps and never shows 0.
2. seed_load = 1 with seed = 0 → next lfsr_state = 0x02F. seed_load = 1 with seed = 0x155 → next state = 0x155.
3. req with range_lim = 1 → valid pulses exactly 2 cycles after req is sampled, out = 0, fallback = 0, busy high for 1 cycle.
4. 10000 draws with range_lim = 600 → every out < 600, every bucket populated, fallback rate matches the analytic value (0.4^8 per draw) within tolerance, no valid lasts longer than 1 cycle.
5. Force rejection by seeding so that 8 consecutive masked candidates are >= 513 with range_lim = 513 → valid at MAX_TRIES + 1 cycles, fallback = 1, out = cand - 513 < 513.
6. Reset_n pulsed low mid-DRAW → busy, valid and out drop to 0 asynchronously; lfsr_state = 0x02F; no valid after release until a new req.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types, default tap masks and the range-to-mask helper for the
// ranged pseudo-random generator.
package rand_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_e;

  // Widest LFSR the mask helper supports; callers narrow the result.
  localparam int MAX_W = 32;
  localparam int CNT_W = 8;

  // Maximal-length Fibonacci tap masks (bit i set means state[i] feeds the XOR).
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [9:0]  TAPS_W10 = 10'h240;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // Smallest 2^k-1 covering range-1. A zero range wraps range-1 to all ones,
  // which yields the full mask without a separate case.
  function automatic logic [MAX_W-1:0] mask_for(input logic [MAX_W-1:0] range_v);
    logic [MAX_W-1:0] top_v;
    logic [MAX_W-1:0] m;
    logic             acc;
    top_v = range_v - MAX_W'(1);
    m     = '0;
    acc   = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      acc  = acc | top_v[i];
      m[i] = acc;
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with runtime seed loading and a zero-state guard.
module lfsr_core
  import rand_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W10,
  parameter logic [WIDTH-1:0] SEED  = 10'h02F
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] step_v;
  logic             fb;

  always_comb begin
    fb     = ^(state_q & TAPS);
    step_v = {state_q[WIDTH-2:0], fb};
    if (seed_load) begin
      state_d = (seed == '0) ? SEED : seed;
    end else begin
      state_d = step_v;
    end
    // The all-zero state is a fixed point of the XOR feedback; never enter it.
    if (state_d == '0) begin
      state_d = SEED;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/random_range_gen.sv
// Request/valid wrapper around lfsr_core returning values uniform in
// [0, range_lim) by bounded rejection sampling with a fold-down fallback.
module random_range_gen
  import rand_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_W10,
  parameter logic [WIDTH-1:0] SEED      = 10'h02F,
  parameter int               MAX_TRIES = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] range_lim,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             fallback,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);

  draw_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             fallback_q, fallback_d;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cand;
  logic             accept;
  logic             last_try;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (lfsr_state)
  );

  // Candidate comes from the pre-step state; once cand >= range it is below 2*range.
  always_comb begin
    mask     = WIDTH'(mask_for(MAX_W'(range_q)));
    cand     = lfsr_state & mask;
    accept   = (range_q == '0) || (cand < range_q);
    last_try = (cnt_q == LAST_TRY);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      range_q    <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      range_q    <= range_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = DRAW;
      DRAW: if (accept || last_try) state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    range_d    = range_q;
    out_d      = out_q;
    fallback_d = fallback_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          range_d = range_lim;
          cnt_d   = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          out_d      = cand;
          fallback_d = 1'b0;
          valid_d    = 1'b1;
        end else if (last_try) begin
          out_d      = cand - range_q;
          fallback_d = 1'b1;
          valid_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign busy     = (state_q == DRAW);
  assign valid    = valid_q;
  assign out      = out_q;
  assign fallback = fallback_q;

endmodule

// File: tb/tb_random_range_gen.sv
// Directed bench for random_range_gen: LFSR sequence and period, seeding,
// latency, fallback, mid-draw seeding/reset and a bulk range sweep.
module tb_random_range_gen;

  localparam int W       = 10;
  localparam int N_DRAWS = 3000;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         seed_load;
  logic [W-1:0] seed;
  logic         req;
  logic [W-1:0] range_lim;
  logic         busy;
  logic         valid;
  logic [W-1:0] out;
  logic         fallback;
  logic [W-1:0] lfsr_state;

  int total = 0;
  int bad   = 0;
  bit seen [0:599];

  always #5 Clk = ~Clk;

  random_range_gen dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .req        (req),
    .range_lim  (range_lim),
    .busy       (busy),
    .valid      (valid),
    .out        (out),
    .fallback   (fallback),
    .lfsr_state (lfsr_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int steps;
    bit zero_seen;
    bit any_valid;
    bit any_busy;
    bit got;
    int cyc;
    int fb_cnt;
    int distinct;

    Reset_n   = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    req       = 1'b0;
    range_lim = '0;

    // Reset values
    #12;
    check("rst_lfsr", lfsr_state, 10'h02F);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_fallback", fallback, 1'b0);
    tick();
    Reset_n = 1'b1;
    check("rel_lfsr0", lfsr_state, 10'h02F);

    // Sequence and period
    tick();
    check("lfsr_step1", lfsr_state, 10'h05E);
    tick();
    check("lfsr_step2", lfsr_state, 10'h0BD);
    steps     = 2;
    zero_seen = 1'b0;
    while (steps < 1100) begin
      tick();
      steps++;
      if (lfsr_state == '0) zero_seen = 1'b1;
      if (lfsr_state == 10'h02F) break;
    end
    check("lfsr_period", steps, 1023);
    check("lfsr_no_zero", zero_seen, 1'b0);

    // Seed loading, including zero-seed substitution
    seed_load = 1'b1;
    seed      = 10'h155;
    tick();
    check("seed_155", lfsr_state, 10'h155);
    seed = '0;
    tick();
    check("seed_zero", lfsr_state, 10'h02F);
    seed_load = 1'b0;

    // range_lim = 1: best-case latency, range changed mid-draw ignored
    req       = 1'b1;
    range_lim = 10'd1;
    tick();
    req       = 1'b0;
    range_lim = 10'h3FF;
    check("r1_busy", busy, 1'b1);
    check("r1_valid_early", valid, 1'b0);
    tick();
    check("r1_valid", valid, 1'b1);
    check("r1_out", out, '0);
    check("r1_fallback", fallback, 1'b0);
    check("r1_busy_done", busy, 1'b0);

    // New req in the valid cycle, together with seed_load; range 0 returns raw state
    req       = 1'b1;
    range_lim = '0;
    seed_load = 1'b1;
    seed      = 10'h155;
    tick();
    req       = 1'b0;
    seed_load = 1'b0;
    check("b2b_valid_pulse", valid, 1'b0);
    check("b2b_busy", busy, 1'b1);
    check("b2b_out_held", out, '0);
    check("b2b_lfsr", lfsr_state, 10'h155);
    tick();
    check("r0_valid", valid, 1'b1);
    check("r0_out", out, 10'h155);
    check("r0_fallback", fallback, 1'b0);
    tick();
    check("r0_valid_drop", valid, 1'b0);
    check("r0_out_held", out, 10'h155);
    check("r0_idle", busy, 1'b0);

    // Forced fallback: seed 0x3FF gives 8 candidates >= 513, last one 0x380
    seed_load = 1'b1;
    seed      = 10'h3FF;
    req       = 1'b1;
    range_lim = 10'd513;
    tick();
    seed_load = 1'b0;
    req       = 1'b0;
    range_lim = '0;
    any_valid = 1'b0;
    any_busy  = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (valid) any_valid = 1'b1;
      if (!busy) any_busy = 1'b0;
      if (i == 3) req = 1'b1;
      if (i == 4) req = 1'b0;
    end
    check("fb_no_early_valid", any_valid, 1'b0);
    check("fb_busy_held", any_busy, 1'b1);
    tick();
    check("fb_valid", valid, 1'b1);
    check("fb_flag", fallback, 1'b1);
    check("fb_out", out, 10'd383);
    check("fb_busy_done", busy, 1'b0);
    tick();
    check("fb_valid_drop", valid, 1'b0);
    check("fb_req_ignored", busy, 1'b0);

    // seed_load mid-draw: draw continues on the reloaded state
    seed_load = 1'b1;
    seed      = 10'h3FF;
    req       = 1'b1;
    range_lim = 10'd513;
    tick();
    seed_load = 1'b0;
    req       = 1'b0;
    tick();
    check("mid_seed_busy1", busy, 1'b1);
    seed_load = 1'b1;
    seed      = 10'h005;
    tick();
    seed_load = 1'b0;
    check("mid_seed_busy2", busy, 1'b1);
    check("mid_seed_lfsr", lfsr_state, 10'h005);
    tick();
    check("mid_seed_valid", valid, 1'b1);
    check("mid_seed_out", out, 10'h005);
    check("mid_seed_fallback", fallback, 1'b0);

    // Asynchronous reset in the middle of a draw
    seed_load = 1'b1;
    seed      = 10'h3FF;
    req       = 1'b1;
    range_lim = 10'd513;
    tick();
    seed_load = 1'b0;
    req       = 1'b0;
    tick();
    tick();
    check("arst_pre_busy", busy, 1'b1);
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", valid, 1'b0);
    check("arst_out", out, '0);
    check("arst_fallback", fallback, 1'b0);
    check("arst_lfsr", lfsr_state, 10'h02F);
    #1;
    Reset_n = 1'b1;
    tick();
    check("arst_lfsr_step", lfsr_state, 10'h05E);
    any_valid = 1'b0;
    any_busy  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (valid) any_valid = 1'b1;
      if (busy) any_busy = 1'b1;
      tick();
    end
    check("arst_no_valid", any_valid, 1'b0);
    check("arst_no_busy", any_busy, 1'b0);

    // Bulk draws with range 600
    fb_cnt = 0;
    for (int d = 0; d < N_DRAWS; d++) begin
      req       = 1'b1;
      range_lim = 10'd600;
      tick();
      req = 1'b0;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 9) begin
        tick();
        cyc++;
        if (valid) got = 1'b1;
      end
      check("bulk_valid_in_budget", got, 1'b1);
      if (got) begin
        check("bulk_out_lt_600", out < 10'd600, 1'b1);
        if (out < 10'd600) seen[out] = 1'b1;
        if (fallback) fb_cnt++;
        tick();
        check("bulk_valid_one_cycle", valid, 1'b0);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    distinct = 0;
    for (int v = 0; v < 600; v++) if (seen[v]) distinct++;
    check("bulk_coverage", distinct >= 450, 1'b1);
    check("bulk_fallback_rare", fb_cnt <= 60, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
